// File: rtl/tc_ram_burst_dma.sv
// Burst fill/copy engine driving a TC RAM port: one command at a time,
// FILL writes a constant to N words, COPY moves N words in ascending order.
module tc_ram_burst_dma #(
  parameter int    UUID       = 0,
  parameter string NAME       = "",
  parameter int    WORD_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dst,
  input  logic [31:0] cmd_len,
  input  logic [63:0] cmd_value,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] words_done,
  output logic        ram_load,
  output logic        ram_save,
  output logic [31:0] ram_address,
  output logic [63:0] ram_in0,
  input  logic [63:0] ram_out0
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam logic [DATA_W-1:0] DATA_MASK = {DATA_W{1'b1}} >> (DATA_W - WORD_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [ADDR_W-1:0]   rem;

  // Instance identification only; kept referenced so it stays visible in the netlist.
  logic unused_cfg;
  assign unused_cfg = (UUID != 0) || (NAME != "");

  // RAM outputs are registered on the transition into each state, so they
  // are stable for a full half-cycle before the RAM's falling-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      words_done  <= '0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= '0;
      ram_in0     <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      rem         <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            words_done <= '0;
            src_ptr    <= cmd_src;
            dst_ptr    <= cmd_dst;
            rem        <= cmd_len;
            if (cmd_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (!cmd_op) begin
              state       <= S_FILL;
              ram_save    <= 1'b1;
              ram_address <= cmd_dst;
              ram_in0     <= cmd_value & DATA_MASK;
            end else begin
              state       <= S_RD;
              ram_load    <= 1'b1;
              ram_address <= cmd_src;
            end
          end
        end

        S_FILL: begin
          // The word saved this cycle is always counted, even on abort.
          words_done <= words_done + 32'd1;
          dst_ptr    <= dst_ptr + 32'd1;
          rem        <= rem - 32'd1;
          if (abort || rem == 32'd1) begin
            state    <= S_DONE;
            ram_save <= 1'b0;
            done     <= 1'b1;
            aborted  <= abort;
          end else begin
            ram_address <= dst_ptr + 32'd1;
          end
        end

        S_RD: begin
          ram_load <= 1'b0;
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state       <= S_WR;
            ram_save    <= 1'b1;
            ram_address <= dst_ptr;
            ram_in0     <= ram_out0 & DATA_MASK;
          end
        end

        S_WR: begin
          words_done <= words_done + 32'd1;
          src_ptr    <= src_ptr + 32'd1;
          dst_ptr    <= dst_ptr + 32'd1;
          rem        <= rem - 32'd1;
          ram_save   <= 1'b0;
          if (abort || rem == 32'd1) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= abort;
          end else begin
            state       <= S_RD;
            ram_load    <= 1'b1;
            ram_address <= src_ptr + 32'd1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          ram_load  <= 1'b0;
          ram_save  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_ram_burst_dma.sv
// Randomized bench for tc_ram_burst_dma: a 64-bit and a 16-bit instance share
// the command stream, each with its own RAM, checked against a word-level model.
`timescale 1ns/1ps
module tb_tc_ram_burst_dma;

  localparam logic [63:0] MASK16 = 64'h0000_0000_0000_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [31:0] cmd_len = '0;
  logic [63:0] cmd_value = '0;
  logic        abort = 1'b0;

  logic        cmd_ready, busy, done, aborted, ram_load, ram_save;
  logic [31:0] words_done, ram_address;
  logic [63:0] ram_in0, ram_out0;

  logic        h_cmd_ready, h_busy, h_done, h_aborted, h_ram_load, h_ram_save;
  logic [31:0] h_words_done, h_ram_address;
  logic [63:0] h_ram_in0, h_ram_out0;

  logic [63:0] mem64 [logic [31:0]];
  logic [63:0] mem16 [logic [31:0]];
  logic [63:0] ref64 [logic [31:0]];
  logic [63:0] ref16 [logic [31:0]];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tc_ram_burst_dma #(.UUID(1), .NAME("dma64"), .WORD_WIDTH(64)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_value(cmd_value), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .words_done(words_done), .ram_load(ram_load),
    .ram_save(ram_save), .ram_address(ram_address), .ram_in0(ram_in0),
    .ram_out0(ram_out0)
  );

  tc_ram_burst_dma #(.UUID(2), .NAME("dma16"), .WORD_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(h_cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_value(cmd_value), .abort(abort), .busy(h_busy), .done(h_done),
    .aborted(h_aborted), .words_done(h_words_done), .ram_load(h_ram_load),
    .ram_save(h_ram_save), .ram_address(h_ram_address), .ram_in0(h_ram_in0),
    .ram_out0(h_ram_out0)
  );

  // RAMs write on the falling edge; read data follows the held address.
  always @(negedge clk) begin
    if (ram_save) mem64[ram_address] = ram_in0;
    if (h_ram_save) mem16[h_ram_address] = h_ram_in0;
    ram_out0   = mem64.exists(ram_address) ? mem64[ram_address] : 64'd0;
    h_ram_out0 = mem16.exists(h_ram_address) ? mem16[h_ram_address] : 64'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] peek(input int which, input logic [31:0] a);
    case (which)
      0: return mem64.exists(a) ? mem64[a] : 64'd0;
      1: return mem16.exists(a) ? mem16[a] : 64'd0;
      2: return ref64.exists(a) ? ref64[a] : 64'd0;
      default: return ref16.exists(a) ? ref16[a] : 64'd0;
    endcase
  endfunction

  task automatic poke(input logic [31:0] a, input logic [63:0] v);
    mem64[a] = v;
    mem16[a] = v;
    ref64[a] = v;
    ref16[a] = v;
  endtask

  task automatic check_mem(input logic [31:0] a);
    check($sformatf("mem64[%h]", a), peek(0, a), peek(2, a));
    check($sformatf("mem16[%h]", a), peek(1, a), peek(3, a));
  endtask

  // ab = cycle after accept in which abort is held high (0 = never).
  task automatic run_cmd(input logic op, input logic [31:0] src, input logic [31:0] dst,
                         input int len, input logic [63:0] val, input int ab);
    int exp_words, exp_done, done_at, saves, w;
    logic exp_ab, both, upper, seen;
    logic [31:0] a;

    if (!op) begin
      exp_ab    = (ab >= 1) && (ab <= len);
      exp_words = exp_ab ? ab : len;
      exp_done  = exp_ab ? ab + 1 : len + 1;
    end else begin
      exp_ab    = (ab >= 1) && (ab <= 2 * len);
      exp_words = exp_ab ? ab / 2 : len;
      exp_done  = exp_ab ? ab + 1 : 2 * len + 1;
    end
    for (int i = 0; i < exp_words; i++) begin
      a = dst + 32'(i);
      if (!op) begin
        ref64[a] = val;
        ref16[a] = val & MASK16;
      end else begin
        ref64[a] = peek(2, src + 32'(i));
        ref16[a] = peek(3, src + 32'(i)) & MASK16;
      end
    end

    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = 32'(len);
    cmd_value = val;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    seen = 1'b0; both = 1'b0; upper = 1'b0; saves = 0; done_at = 0;
    for (int cy = 1; cy <= 2 * len + 10 && !seen; cy++) begin
      @(negedge clk);
      abort = (cy == ab);
      if (cy == 1) begin
        check("busy_c1", {63'd0, busy}, 64'd1);
        check("wd_clear", 64'(words_done), 64'd0);
      end
      if (ram_load && ram_save) both = 1'b1;
      if (h_ram_load && h_ram_save) both = 1'b1;
      if (ram_save) saves++;
      if (h_ram_save && h_ram_in0[63:16] != 48'd0) upper = 1'b1;
      if (done) begin
        seen    = 1'b1;
        done_at = cy;
        check("aborted", {63'd0, aborted}, {63'd0, exp_ab});
        check("words_done", 64'(words_done), 64'(exp_words));
        check("ready_in_done", {63'd0, cmd_ready}, 64'd0);
        check("done16", {63'd0, h_done}, 64'd1);
        check("aborted16", {63'd0, h_aborted}, {63'd0, exp_ab});
        check("words_done16", 64'(h_words_done), 64'(exp_words));
      end
    end
    abort = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    check("done_cycle", 64'(done_at), 64'(exp_done));
    check("save_cycles", 64'(saves), 64'(exp_words));
    check("ld_sv_excl", {63'd0, both}, 64'd0);
    check("in0_upper16", {63'd0, upper}, 64'd0);

    @(negedge clk);
    check("ready_after", {63'd0, cmd_ready}, 64'd1);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("wd_hold", 64'(words_done), 64'(exp_words));
    for (int i = -1; i <= len; i++) check_mem(dst + 32'(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    logic [31:0] src, dst;
    int len, ab;
    logic op;

    #1 rst = 1'b0;
    #1;
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_aborted", {63'd0, aborted}, 64'd0);
    check("rst_wd", 64'(words_done), 64'd0);
    check("rst_ldsv", {62'd0, ram_load, ram_save}, 64'd0);
    check("rst_addr", 64'(ram_address), 64'd0);
    check("rst_in0", ram_in0, 64'd0);
    check("rst_ready16", {63'd0, h_cmd_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_cmd(1'b0, 32'h0, 32'h10, 4, 64'hDEADBEEF, 0);
    check("fill_word3", peek(0, 32'h13), 64'hDEADBEEF);

    poke(32'h0, 64'd1); poke(32'h1, 64'd2); poke(32'h2, 64'd3);
    run_cmd(1'b1, 32'h0, 32'h20, 3, 64'd0, 0);
    check("copy_word2", peek(0, 32'h22), 64'd3);

    poke(32'h0, 64'd7);
    run_cmd(1'b1, 32'h0, 32'h1, 3, 64'd0, 0);
    check("overlap_word3", peek(0, 32'h3), 64'd7);

    run_cmd(1'b0, 32'h0, 32'hFFFF_FFFF, 2, 64'h55, 0);
    check("wrap_top", peek(0, 32'hFFFF_FFFF), 64'h55);
    check("wrap_zero", peek(0, 32'h0), 64'h55);

    run_cmd(1'b0, 32'h0, 32'h30, 0, 64'h77, 0);
    run_cmd(1'b0, 32'h0, 32'h40, 8, 64'h99, 3);
    check("abort_last", peek(0, 32'h42), 64'h99);
    check("abort_next", peek(0, 32'h43), 64'd0);

    poke(32'h50, 64'h1234_5678_9ABC_ABCD);
    run_cmd(1'b1, 32'h50, 32'h60, 1, 64'd0, 0);
    check("ww16_copy", peek(1, 32'h60), 64'h0000_0000_0000_ABCD);
    check("ww64_copy", peek(0, 32'h60), 64'h1234_5678_9ABC_ABCD);

    run_cmd(1'b1, 32'h20, 32'h68, 4, 64'd0, 4);
    run_cmd(1'b1, 32'h20, 32'h70, 4, 64'd0, 5);

    // Reset in the second FILL cycle: only the first word may land.
    v = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dst = 32'h80; cmd_len = 32'd8; cmd_value = v;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_save", {63'd0, ram_save}, 64'd0);
    check("mid_rst_save16", {63'd0, h_ram_save}, 64'd0);
    check("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_wd", 64'(words_done), 64'd0);
    check("mid_rst_addr", 64'(ram_address), 64'd0);
    check("mid_rst_in0", ram_in0, 64'd0);
    ref64[32'h80] = v;
    ref16[32'h80] = v & MASK16;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
    check_mem(32'h80);
    check_mem(32'h81);

    for (int i = 0; i < 64; i++) poke(32'(i), {$urandom, $urandom});
    for (int t = 0; t < 40; t++) begin
      op  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 6));
      src = 32'($urandom_range(0, 40));
      dst = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) dst = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      v   = {$urandom, $urandom};
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * len + 1)) : 0;
      run_cmd(op, src, dst, len, v, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
